// File: rtl/acc_dump_tx.sv
// acc_dump_tx: streams an {HEADER, ACC, PC} snapshot frame to the debug UART TX.
// Define ACC_DUMP_CHECKSUM_EN to append a running-XOR checksum byte.
module acc_dump_tx #(
  parameter int         NBITS_D  = 16,
  parameter int         NBITS_PC = 11,
  parameter logic [7:0] HEADER   = 8'hA5
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NBITS_D-1:0]  i_ACC,
  input  logic [NBITS_PC-1:0] i_PC,
  input  logic                i_trigger,
  input  logic                i_tx_ready,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  output logic                o_busy,
  output logic                o_done
);

  localparam int ACC_BYTES = (NBITS_D + 7) / 8;
  localparam int PC_BYTES  = (NBITS_PC + 7) / 8;
  localparam int MAX_BYTES = (ACC_BYTES > PC_BYTES) ? ACC_BYTES : PC_BYTES;
  localparam int IDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int ACC_W     = ACC_BYTES * 8;
  localparam int PC_W      = PC_BYTES * 8;

  localparam logic [IDX_W-1:0] ACC_LAST = IDX_W'(ACC_BYTES - 1);
  localparam logic [IDX_W-1:0] PC_LAST  = IDX_W'(PC_BYTES - 1);

`ifdef ACC_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_ACC, S_PC, S_CHK
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_HDR, S_ACC, S_PC
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [NBITS_D-1:0]   acc_q, acc_d;
  logic [NBITS_PC-1:0]  pc_q, pc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic [IDX_W-1:0]     idx_inc;
  logic [ACC_W-1:0]     acc_ext;
  logic [PC_W-1:0]      pc_ext;
  logic [7:0]           acc_nx;
  logic [7:0]           pc_nx;

  assign accept  = tx_valid_q & i_tx_ready;
  assign idx_inc = idx_q + IDX_W'(1);
  assign acc_ext = ACC_W'(acc_q);
  assign pc_ext  = PC_W'(pc_q);

  // Byte idx_inc of the zero-extended snapshot, MSB byte first
  assign acc_nx = acc_ext[(ACC_W - 1) - {idx_inc, 3'b000} -: 8];
  assign pc_nx  = pc_ext[(PC_W - 1) - {idx_inc, 3'b000} -: 8];

`ifdef ACC_DUMP_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;

  always_comb begin
    xor_d = xor_q;
    if (state_q == S_IDLE && i_trigger)
      xor_d = '0;
    else if (accept)
      xor_d = xor_q ^ tx_data_q;
  end
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    pc_d       = pc_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_trigger) begin
          acc_d      = i_ACC;
          pc_d       = i_PC;
          idx_d      = '0;
          state_d    = S_HDR;
          tx_data_d  = HEADER;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      S_HDR: begin
        if (accept) begin
          state_d   = S_ACC;
          idx_d     = '0;
          tx_data_d = acc_ext[ACC_W-1 -: 8];
        end
      end
      S_ACC: begin
        if (accept) begin
          if (idx_q == ACC_LAST) begin
            state_d   = S_PC;
            idx_d     = '0;
            tx_data_d = pc_ext[PC_W-1 -: 8];
          end else begin
            idx_d     = idx_inc;
            tx_data_d = acc_nx;
          end
        end
      end
      S_PC: begin
        if (accept) begin
          if (idx_q == PC_LAST) begin
`ifdef ACC_DUMP_CHECKSUM_EN
            state_d    = S_CHK;
            idx_d      = '0;
            tx_data_d  = xor_d;
`else
            state_d    = S_IDLE;
            idx_d      = '0;
            tx_data_d  = '0;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
`endif
          end else begin
            idx_d     = idx_inc;
            tx_data_d = pc_nx;
          end
        end
      end
`ifdef ACC_DUMP_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_d    = S_IDLE;
          idx_d      = '0;
          tx_data_d  = '0;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
      end
`endif
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      pc_q       <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ACC_DUMP_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      pc_q       <= pc_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef ACC_DUMP_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_acc_dump_tx.sv
// tb_acc_dump_tx: randomized frame checks of acc_dump_tx against a byte-list model.
// Covers reset, stalls, snapshot, ignored triggers, abort, back-to-back and 12-bit ACC.
module tb_acc_dump_tx;

`ifdef ACC_DUMP_CHECKSUM_EN
  localparam int FL = 6;
`else
  localparam int FL = 5;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] acc;
  logic [10:0] pc;
  logic        trig, rdy;
  logic [7:0]  dat;
  logic        val, busy, done;

  logic [11:0] acc2;
  logic [10:0] pc2;
  logic        trig2, rdy2;
  logic [7:0]  dat2;
  logic        val2, busy2, done2;

  acc_dump_tx u_dut (
    .i_clk(clk), .i_reset(rst), .i_ACC(acc), .i_PC(pc),
    .i_trigger(trig), .i_tx_ready(rdy),
    .o_tx_data(dat), .o_tx_valid(val), .o_busy(busy), .o_done(done)
  );

  acc_dump_tx #(.NBITS_D(12), .NBITS_PC(11)) u_dut12 (
    .i_clk(clk), .i_reset(rst), .i_ACC(acc2), .i_PC(pc2),
    .i_trigger(trig2), .i_tx_ready(rdy2),
    .o_tx_data(dat2), .o_tx_valid(val2), .o_busy(busy2), .o_done(done2)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pat = 0;
  int rdy_mode = 0;

  logic [7:0] got[$];
  logic [7:0] got2[$];
  logic [7:0] exp_q[$];
  int         acc_edge[$];
  int         done_cnt, done2_cnt, done_edge, busy_cnt, stall_viol;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: records accepted bytes and protocol violations
  always @(negedge clk) begin
    if (prev_stall && (!val || dat !== prev_data)) stall_viol++;
    if (busy && !val) stall_viol++;
    prev_stall = val && !rdy && !rst;
    prev_data  = dat;
    if (val && rdy) begin
      got.push_back(dat);
      acc_edge.push_back(cyc + 1);
    end
    if (done) begin
      done_cnt++;
      done_edge = cyc;
    end
    if (busy) busy_cnt++;
    if (val2 && rdy2) got2.push_back(dat2);
    if (done2) done2_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    pat++;
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = ($urandom_range(0, 2) != 0);
      default: rdy = (pat % 4 == 3);
    endcase
  endtask

  task automatic clear_mon();
    got.delete();
    got2.delete();
    acc_edge.delete();
    exp_q.delete();
    done_cnt   = 0;
    done2_cnt  = 0;
    done_edge  = -1;
    busy_cnt   = 0;
    stall_viol = 0;
  endtask

  // Reference frame from the byte-order rules, appended to exp_q
  task automatic model_frame(input logic [31:0] a, input logic [31:0] p,
                             input int ab, input int pb);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'hA5;
    exp_q.push_back(8'hA5);
    for (int k = ab - 1; k >= 0; k--) begin
      b = 8'((a >> (8 * k)) & 32'hFF);
      exp_q.push_back(b);
      x = x ^ b;
    end
    for (int k = pb - 1; k >= 0; k--) begin
      b = 8'((p >> (8 * k)) & 32'hFF);
      exp_q.push_back(b);
      x = x ^ b;
    end
`ifdef ACC_DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    tests++;
    if (dat !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", dat); end
    tests++;
    if (val !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", val); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++;
    if (val2 !== 1'b0 || busy2 !== 1'b0) begin
      fails++; $display("FAIL reset_dut12: got v=%b b=%b want 0 0", val2, busy2);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int n0, n;
    clear_mon();
    rdy_mode = 0;
    rdy = 1'b1;
    acc = 16'h1234;
    pc  = 11'h005;
    trig = 1'b1;
    step();
    n0 = cyc;
    trig = 1'b0;
    model_frame(32'h1234, 32'h005, 2, 2);
    n = 0;
    while (done_cnt == 0 && n < 100) begin step(); n++; end
    repeat (3) step();
    tests++;
    if (got.size() != FL) begin fails++; $display("FAIL basic_len: got %0d want %0d", got.size(), FL); end
    for (int k = 0; k < FL; k++) begin
      logic [7:0] g;
      int e;
      g = (k < got.size()) ? got[k] : 8'hxx;
      e = (k < acc_edge.size()) ? acc_edge[k] : -1;
      tests++;
      if (g !== exp_q[k]) begin fails++; $display("FAIL basic_byte%0d: got %h want %h", k, g, exp_q[k]); end
      tests++;
      if (e != n0 + 1 + k) begin fails++; $display("FAIL basic_edge%0d: got %0d want %0d", k, e, n0 + 1 + k); end
    end
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
    tests++;
    if (done_edge != n0 + FL) begin fails++; $display("FAIL basic_done_edge: got %0d want %0d", done_edge, n0 + FL); end
    tests++;
    if (busy_cnt != FL) begin fails++; $display("FAIL basic_busy_cycles: got %0d want %0d", busy_cnt, FL); end
  endtask

  // Drives one frame; noise changes i_ACC/i_PC and pulses i_trigger mid-frame
  task automatic run_frame(input logic [15:0] a, input logic [10:0] p,
                           input int mode, input bit noise, input string nm);
    int n;
    clear_mon();
    rdy_mode = mode;
    acc = a;
    pc  = p;
    trig = 1'b1;
    step();
    trig = 1'b0;
    model_frame(32'(a), 32'(p), 2, 2);
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      if (noise) begin
        acc = 16'($urandom);
        pc  = 11'($urandom);
        trig = (got.size() <= FL - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      step();
      n++;
    end
    trig = 1'b0;
    rdy_mode = 0;
    repeat (6) step();
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL %s_done_cnt: got %0d want 1", nm, done_cnt); end
    tests++;
    if (got.size() != FL) begin fails++; $display("FAIL %s_len: got %0d want %0d", nm, got.size(), FL); end
    for (int k = 0; k < FL; k++) begin
      logic [7:0] g;
      g = (k < got.size()) ? got[k] : 8'hxx;
      tests++;
      if (g !== exp_q[k]) begin fails++; $display("FAIL %s_byte%0d: got %h want %h", nm, k, g, exp_q[k]); end
    end
    tests++;
    if (stall_viol != 0) begin fails++; $display("FAIL %s_stable: got %0d violations want 0", nm, stall_viol); end
  endtask

  task automatic test_stall();
    run_frame(16'h1234, 11'h005, 2, 1'b0, "stall");
  endtask

  task automatic test_snapshot();
    run_frame(16'h1234, 11'h005, 0, 1'b1, "snapshot");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_frame(16'($urandom), 11'($urandom), 1, 1'b1, "random");
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    rdy_mode = 0;
    acc = 16'h1234;
    pc  = 11'h005;
    trig = 1'b1;
    step();
    trig = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (val !== 1'b0) begin fails++; $display("FAIL abort_valid: got %b want 0", val); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
    repeat (6) step();
    tests++;
    if (done_cnt != 0) begin fails++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
    run_frame(16'h1234, 11'h005, 0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    int n;
    clear_mon();
    rdy_mode = 0;
    acc = 16'hBEEF;
    pc  = 11'h3A1;
    model_frame(32'hBEEF, 32'h3A1, 2, 2);
    model_frame(32'hBEEF, 32'h3A1, 2, 2);
    trig = 1'b1;
    n = 0;
    while (done_cnt < 2 && n < 100) begin
      if (got.size() >= 2 * FL - 1) trig = 1'b0;
      step();
      n++;
    end
    trig = 1'b0;
    repeat (4) step();
    tests++;
    if (done_cnt != 2) begin fails++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt); end
    tests++;
    if (got.size() != 2 * FL) begin fails++; $display("FAIL b2b_len: got %0d want %0d", got.size(), 2 * FL); end
    for (int k = 0; k < 2 * FL; k++) begin
      logic [7:0] g;
      g = (k < got.size()) ? got[k] : 8'hxx;
      tests++;
      if (g !== exp_q[k]) begin fails++; $display("FAIL b2b_byte%0d: got %h want %h", k, g, exp_q[k]); end
    end
    tests++;
    if (acc_edge.size() < FL + 1 || acc_edge[FL] != acc_edge[FL-1] + 2) begin
      fails++;
      $display("FAIL b2b_restart_gap: got %0d edges want gap 2", acc_edge.size());
    end
  endtask

  task automatic test_reset_and_trigger();
    clear_mon();
    rst  = 1'b1;
    trig = 1'b1;
    step();
    rst  = 1'b0;
    trig = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || val !== 1'b0) begin
      fails++; $display("FAIL rst_trig: got b=%b v=%b want 0 0", busy, val);
    end
    repeat (8) step();
    tests++;
    if (got.size() != 0 || done_cnt != 0) begin
      fails++; $display("FAIL rst_trig_quiet: got %0d bytes %0d dones want 0 0", got.size(), done_cnt);
    end
  endtask

  task automatic test_dut12();
    int n;
    clear_mon();
    acc2 = 12'hABC;
    pc2  = 11'h7FF;
    rdy2 = 1'b1;
    model_frame(32'hABC, 32'h7FF, 2, 2);
    trig2 = 1'b1;
    step();
    trig2 = 1'b0;
    n = 0;
    while (done2_cnt == 0 && n < 100) begin step(); n++; end
    repeat (3) step();
    tests++;
    if (done2_cnt != 1) begin fails++; $display("FAIL d12_done_cnt: got %0d want 1", done2_cnt); end
    tests++;
    if (got2.size() != FL) begin fails++; $display("FAIL d12_len: got %0d want %0d", got2.size(), FL); end
    for (int k = 0; k < FL; k++) begin
      logic [7:0] g;
      g = (k < got2.size()) ? got2[k] : 8'hxx;
      tests++;
      if (g !== exp_q[k]) begin fails++; $display("FAIL d12_byte%0d: got %h want %h", k, g, exp_q[k]); end
    end
  endtask

  initial begin
    rst   = 1'b1;
    trig  = 1'b0;
    rdy   = 1'b1;
    acc   = '0;
    pc    = '0;
    trig2 = 1'b0;
    rdy2  = 1'b1;
    acc2  = '0;
    pc2   = '0;
    clear_mon();
    test_reset();
    test_basic();
    test_stall();
    test_snapshot();
    test_random();
    test_reset_mid();
    test_back_to_back();
    test_reset_and_trigger();
    test_dut12();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
